// File: rtl/alu_issue_if.sv
// Handshake bundle between the register-read stage, the alu_issue stage and the ALU.
// The master side drives instructions and out_ready; the slave side is the issue stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_aluop;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_aluop, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_aluop, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32 OP/OP-IMM/LUI decode-and-issue stage with a registered, skid-buffered output.
// Define ALU_ISSUE_MEXT_EN to decode MUL/DIV (funct7=0000001) from OP.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
`ifdef ALU_ISSUE_MEXT_EN
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic logic [31:0] sext12(input logic signed [11:0] imm);
    logic signed [31:0] wide;
    wide = imm;
    return wide;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  entry_t     dec;

  assign opc = bus.in_instr[6:0];
  assign f3  = bus.in_instr[14:12];
  assign f7  = bus.in_instr[31:25];

  always_comb begin
    legal  = 1'b0;
    dec    = '0;
    dec.rd = bus.in_instr[11:7];
    case (opc)
      7'b0110011: begin
        dec.a = bus.in_rs1_data;
        dec.b = bus.in_rs2_data;
        case (f7)
          7'b0000000: begin
            legal  = 1'b1;
            dec.op = base_op(f3);
          end
          7'b0100000: begin
            if (f3 == 3'b000) begin
              legal  = 1'b1;
              dec.op = OP_SUB;
            end else if (f3 == 3'b101) begin
              legal  = 1'b1;
              dec.op = OP_SRA;
            end
          end
`ifdef ALU_ISSUE_MEXT_EN
          7'b0000001: begin
            if (f3 == 3'b000) begin
              legal  = 1'b1;
              dec.op = OP_MUL;
            end else if (f3 == 3'b100) begin
              legal  = 1'b1;
              dec.op = OP_DIV;
            end
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.a = bus.in_rs1_data;
        case (f3)
          3'b001: begin
            legal  = (f7 == 7'b0000000);
            dec.op = OP_SLL;
            dec.b  = {27'b0, bus.in_instr[24:20]};
          end
          3'b101: begin
            legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec.op = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
            dec.b  = {27'b0, bus.in_instr[24:20]};
          end
          default: begin
            // SLTIU also takes the sign-extended immediate; the ALU compares unsigned.
            legal  = 1'b1;
            dec.op = base_op(f3);
            dec.b  = sext12(bus.in_instr[31:20]);
          end
        endcase
      end
      7'b0110111: begin
        legal  = 1'b1;
        dec.op = OP_ADD;
        dec.b  = {bus.in_instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept, issue;

  assign accept = bus.in_valid && !skid_valid_q;
  assign issue  = out_valid_q && bus.out_ready;

  // Accept and issue together with the skid full is impossible: in_ready is low then.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (issue && skid_valid_q) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || issue)) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_aluop   = out_q.op;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_illegal = out_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected issues are queued on accept and compared on issue.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t prev_obs;
  logic prev_stall = 1'b0;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] op, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t obs();
    return {bus.out_a, bus.out_b, bus.out_aluop, bus.out_rd, bus.out_illegal};
  endfunction

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'd1 << 15) | (32'(k) << 7) | 32'h13;
  endfunction

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkp(input string tag, input exp_t o, input exp_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed a=%h b=%h op=%0d rd=%0d ill=%b expected a=%h b=%h op=%0d rd=%0d ill=%b",
             tag, o.a, o.b, o.op, o.rd, o.ill, e.a, e.b, e.op, e.rd, e.ill);
    end
  endtask

  // Scoreboard pop and stall-hold monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chkp("stall_hold", obs(), prev_obs);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=issue expected=no_issue");
        end
        if (q.size() != 0) chkp("sb_issue", obs(), q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_obs   = obs();
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] rs1,
                      input logic [31:0] rs2, input exp_t e);
    logic rdy;
    int   n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.in_instr    = instr;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    do begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (rdy) q.push_back(e);
    checks++;
    assert (rdy) else begin
      errors++;
      $error("FAIL accept_timeout observed in_ready=0 expected in_ready=1 within 50 cycles");
    end
  endtask

  task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, input exp_t e);
    send(instr, rs1, rs2, e);
    chk1({tag, "_latency"}, bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed pending=%0d expected pending=0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkp("rst_payload", obs(), mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);

    single("addi", 32'hFFF00293, 32'h7, 32'h0, mk(32'h7, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0));
    single("sub", 32'h402081B3, 32'd10, 32'd3, mk(32'd10, 32'd3, 5'd1, 5'd3, 1'b0));
    single("srai", 32'h40435393, 32'h80000000, 32'h5, mk(32'h80000000, 32'd4, 5'd7, 5'd7, 1'b0));
    single("lui", 32'h123450B7, 32'hDEAD, 32'hBEEF, mk(32'h0, 32'h12345000, 5'd0, 5'd1, 1'b0));
    single("sltiu", 32'hFFF0B113, 32'h55, 32'h0, mk(32'h55, 32'hFFFFFFFF, 5'd4, 5'd2, 1'b0));
    single("slli_badf7", 32'h40109093, 32'h1234, 32'h0, mk(0, 0, 0, 0, 1'b1));
    single("bad_opcode", 32'h0000007F, 32'hFFFF, 32'hFFFF, mk(0, 0, 0, 0, 1'b1));
`ifdef ALU_ISSUE_MEXT_EN
    single("mul", 32'h02C58533, 32'd6, 32'd7, mk(32'd6, 32'd7, 5'd10, 5'd10, 1'b0));
`else
    single("mul", 32'h02C58533, 32'd6, 32'd7, mk(0, 0, 0, 0, 1'b1));
`endif
    drain();

    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(addi_k(k), 32'h100, 32'h0, mk(32'h100, 32'(k), 5'd0, 5'(k), 1'b0));
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #2;
        chk1("stall_in_ready_low", bus.in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk1("stall_in_ready_held", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    bus.out_ready = 1'b0;
    send(32'h402081B3, 32'd10, 32'd3, mk(32'd10, 32'd3, 5'd1, 5'd3, 1'b0));
    send(32'hFFF00293, 32'h7, 32'h0, mk(32'h7, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0));
    chk1("full_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk1("async_rst_out_valid", bus.out_valid, 1'b0);
    chk1("async_rst_in_ready", bus.in_ready, 1'b1);
    chkp("async_rst_payload", obs(), mk(0, 0, 0, 0, 0));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    single("lui_after_rst", 32'h123450B7, 32'h1, 32'h2, mk(32'h0, 32'h12345000, 5'd0, 5'd1, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
